bfly_sched: RTL and testbench

BFLY_SCHED -- requirements
Module: bfly_sched

---
 rtl/bfly_sched.sv | 195 +++++++++++++++++++
 tb/tb_bfly_sched.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bfly_sched.sv
// 8-point radix-2 FFT scheduler: loads samples in bit-reversed order, drives
// an external combinational butterfly for 12 cycles, then unloads in natural
// order. Forward and inverse twiddles are selected by a mode latched per frame.
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_LOAD    | accept 8 input beats, write to mem[bitrev3(n)]
// ST_COMPUTE | one butterfly per cycle, stage s=0..2, butterfly b=0..3
// ST_UNLOAD  | present mem[0..7] on the output handshake
module bfly_sched (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              mode,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic signed [8:0] in_re,
   input  logic signed [8:0] in_im,
   output logic              out_valid,
   input  logic              out_ready,
   output logic signed [8:0] out_re,
   output logic signed [8:0] out_im,
   output logic signed [8:0] bf_inr,
   output logic signed [8:0] bf_ini,
   output logic signed [8:0] bf_yr,
   output logic signed [8:0] bf_yi,
   output logic signed [8:0] bf_wr,
   output logic signed [8:0] bf_wi,
   input  logic signed [8:0] bf_in0r,
   input  logic signed [8:0] bf_in0i,
   input  logic signed [8:0] bf_in1r,
   input  logic signed [8:0] bf_in1i,
   output logic              busy
);

   typedef enum logic [1:0] {
      ST_LOAD    = 2'd0,
      ST_COMPUTE = 2'd1,
      ST_UNLOAD  = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [2:0]        beat_q, beat_d;
   logic [1:0]        stg_q, stg_d;
   logic [1:0]        bfi_q, bfi_d;
   logic              run_q;
   logic              mode_q;
   logic signed [8:0] mem_re_q [8];
   logic signed [8:0] mem_im_q [8];

   logic              in_fire, out_fire, last_bf;
   logic [2:0]        i0, i1, wr_addr;
   logic [1:0]        tw_k;
   logic signed [8:0] tw_re, tw_im;

   assign in_fire  = in_valid & in_ready;
   assign out_fire = out_valid & out_ready;
   assign last_bf  = (stg_q == 2'd2) && (bfi_q == 2'd3);
   assign wr_addr  = {beat_q[0], beat_q[1], beat_q[2]};
   assign i1       = i0 | (3'd1 << stg_q);

   // Butterfly operand indices and twiddle exponent for the current (s, b)
   always_comb begin
      i0   = '0;
      tw_k = '0;
      case (stg_q)
         2'd0: begin
            i0   = {bfi_q, 1'b0};
            tw_k = 2'd0;
         end
         2'd1: begin
            i0   = {bfi_q[1], 1'b0, bfi_q[0]};
            tw_k = {bfi_q[0], 1'b0};
         end
         default: begin
            i0   = {1'b0, bfi_q};
            tw_k = bfi_q;
         end
      endcase
   end

   // Twiddle ROM, Q8 format, indexed by latched direction and exponent
   always_comb begin
      tw_re = '0;
      tw_im = '0;
      case ({mode_q, tw_k})
         3'b000: begin tw_re = 9'sh0FF; tw_im = 9'sh000; end
         3'b001: begin tw_re = 9'sh0B5; tw_im = 9'sh14B; end
         3'b010: begin tw_re = 9'sh000; tw_im = 9'sh100; end
         3'b011: begin tw_re = 9'sh14B; tw_im = 9'sh14B; end
         3'b100: begin tw_re = 9'sh0FF; tw_im = 9'sh000; end
         3'b101: begin tw_re = 9'sh0B5; tw_im = 9'sh0B5; end
         3'b110: begin tw_re = 9'sh000; tw_im = 9'sh0FF; end
         default: begin tw_re = 9'sh14B; tw_im = 9'sh0B5; end
      endcase
   end

   // State and counter registers; run_q keeps in_ready low until the first edge after reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_LOAD;
         beat_q  <= '0;
         stg_q   <= '0;
         bfi_q   <= '0;
         run_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         stg_q   <= stg_d;
         bfi_q   <= bfi_d;
         run_q   <= 1'b1;
      end
   end

   // Next-state and counter advance
   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      stg_d   = stg_q;
      bfi_d   = bfi_q;
      case (state_q)
         ST_LOAD: begin
            if (in_fire) begin
               beat_d = beat_q + 3'd1;
               if (beat_q == 3'd7) state_d = ST_COMPUTE;
            end
         end
         ST_COMPUTE: begin
            bfi_d = bfi_q + 2'd1;
            if (bfi_q == 2'd3) stg_d = stg_q + 2'd1;
            if (last_bf) begin
               stg_d   = '0;
               state_d = ST_UNLOAD;
            end
         end
         ST_UNLOAD: begin
            if (out_fire) begin
               beat_d = beat_q + 3'd1;
               if (beat_q == 3'd7) state_d = ST_LOAD;
            end
         end
         default: state_d = ST_LOAD;
      endcase
   end

   // Outputs decoded from state; everything not owned by the state is driven to zero
   always_comb begin
      in_ready  = run_q && (state_q == ST_LOAD);
      out_valid = (state_q == ST_UNLOAD);
      busy      = (state_q == ST_COMPUTE) || (state_q == ST_UNLOAD);
      out_re    = '0;
      out_im    = '0;
      bf_inr    = '0;
      bf_ini    = '0;
      bf_yr     = '0;
      bf_yi     = '0;
      bf_wr     = '0;
      bf_wi     = '0;
      if (state_q == ST_UNLOAD) begin
         out_re = mem_re_q[beat_q];
         out_im = mem_im_q[beat_q];
      end
      if (state_q == ST_COMPUTE) begin
         bf_inr = mem_re_q[i0];
         bf_ini = mem_im_q[i0];
         bf_yr  = mem_re_q[i1];
         bf_yi  = mem_im_q[i1];
         bf_wr  = tw_re;
         bf_wi  = tw_im;
      end
   end

   // Sample memory: bit-reversed loads, in-place butterfly write-back, per-frame mode latch
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_q <= 1'b0;
         for (int i = 0; i < 8; i++) begin
            mem_re_q[i] <= '0;
            mem_im_q[i] <= '0;
         end
      end else begin
         if ((state_q == ST_LOAD) && in_fire) begin
            mem_re_q[wr_addr] <= in_re;
            mem_im_q[wr_addr] <= in_im;
            if (beat_q == 3'd0) mode_q <= mode;
         end
         if (state_q == ST_COMPUTE) begin
            mem_re_q[i0] <= bf_in0r;
            mem_im_q[i0] <= bf_in0i;
            mem_re_q[i1] <= bf_in1r;
            mem_im_q[i1] <= bf_in1i;
         end
      end
   end

endmodule

// File: tb/tb_bfly_sched.sv
// Bench for bfly_sched: models the external butterfly (Q8 twiddle multiply,
// 9-bit wrap), and compares every output beat against an array-based FFT.
module tb_bfly_sched;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              mode = 1'b0;
   logic              in_valid = 1'b0;
   logic              out_ready = 1'b0;
   logic signed [8:0] in_re = '0;
   logic signed [8:0] in_im = '0;
   logic              in_ready, out_valid, busy;
   logic signed [8:0] out_re, out_im;
   logic signed [8:0] bf_inr, bf_ini, bf_yr, bf_yi, bf_wr, bf_wi;
   logic signed [8:0] bf_in0r, bf_in0i, bf_in1r, bf_in1i;

   int total = 0;
   int bad = 0;
   int busy_cnt = 0;
   int xr [8];
   int xi [8];
   int er [8];
   int ei [8];
   int twr [2][4] = '{'{255, 181, 0, -181}, '{255, 181, 0, -181}};
   int twi [2][4] = '{'{0, -181, -256, -181}, '{0, 181, 255, 181}};

   always #5 clk = ~clk;

   bfly_sched dut (
      .clk(clk), .rst_n(rst_n), .mode(mode),
      .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_im(in_im),
      .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
      .bf_inr(bf_inr), .bf_ini(bf_ini), .bf_yr(bf_yr), .bf_yi(bf_yi),
      .bf_wr(bf_wr), .bf_wi(bf_wi),
      .bf_in0r(bf_in0r), .bf_in0i(bf_in0i), .bf_in1r(bf_in1r), .bf_in1i(bf_in1i),
      .busy(busy)
   );

   function automatic int wrap9(input int v);
      int t;
      t = v & 511;
      if (t > 255) t = t - 512;
      return t;
   endfunction

   function automatic int mul_r(input int wr, input int wi, input int yr, input int yi);
      return (wr * yr - wi * yi) >>> 8;
   endfunction

   function automatic int mul_i(input int wr, input int wi, input int yr, input int yi);
      return (wr * yi + wi * yr) >>> 8;
   endfunction

   // External butterfly
   assign bf_in0r = 9'(int'(bf_inr) + mul_r(int'(bf_wr), int'(bf_wi), int'(bf_yr), int'(bf_yi)));
   assign bf_in0i = 9'(int'(bf_ini) + mul_i(int'(bf_wr), int'(bf_wi), int'(bf_yr), int'(bf_yi)));
   assign bf_in1r = 9'(int'(bf_inr) - mul_r(int'(bf_wr), int'(bf_wi), int'(bf_yr), int'(bf_yi)));
   assign bf_in1i = 9'(int'(bf_ini) - mul_i(int'(bf_wr), int'(bf_wi), int'(bf_yr), int'(bf_yi)));

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Iterative decimation-in-time FFT over plain arrays
   function automatic void model(input int m);
      int ar [8];
      int ai [8];
      int r, h, a, b, k, pr, pi, tr, ti;
      for (int n = 0; n < 8; n++) begin
         r = ((n & 1) << 2) | (n & 2) | ((n >> 2) & 1);
         ar[r] = xr[n];
         ai[r] = xi[n];
      end
      for (int s = 0; s < 3; s++) begin
         h = 1 << s;
         for (int st = 0; st < 8; st += 2 * h) begin
            for (int j = 0; j < h; j++) begin
               a  = st + j;
               b  = a + h;
               k  = j * (4 / h);
               pr = mul_r(twr[m][k], twi[m][k], ar[b], ai[b]);
               pi = mul_i(twr[m][k], twi[m][k], ar[b], ai[b]);
               tr = ar[a];
               ti = ai[a];
               ar[a] = wrap9(tr + pr);
               ai[a] = wrap9(ti + pi);
               ar[b] = wrap9(tr - pr);
               ai[b] = wrap9(ti - pi);
            end
         end
      end
      for (int n = 0; n < 8; n++) begin
         er[n] = ar[n];
         ei[n] = ai[n];
      end
   endfunction

   task automatic rand_frame();
      for (int n = 0; n < 8; n++) begin
         xr[n] = int'($urandom_range(0, 511)) - 256;
         xi[n] = int'($urandom_range(0, 511)) - 256;
      end
   endtask

   task automatic load_frame(input int m, input bit gaps);
      int  n = 0;
      int  to = 0;
      bit  rdy;
      while (n < 8 && to < 200) begin
         @(negedge clk);
         to++;
         chk("load_in_ready", int'(in_ready), 1);
         chk("load_out_valid", int'(out_valid), 0);
         rdy = in_ready;
         if (gaps && $urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            in_re    = 9'($urandom);
            in_im    = 9'($urandom);
         end else begin
            in_valid = 1'b1;
            in_re    = 9'(xr[n]);
            in_im    = 9'(xi[n]);
         end
         mode = (n == 0) ? 1'(m) : 1'($urandom);
         @(posedge clk);
         if (in_valid && rdy) n++;
      end
      if (n < 8) chk("load_timeout", n, 8);
   endtask

   task automatic compute_phase(input int m);
      int c = 0;
      busy_cnt = 0;
      while (c < 40) begin
         @(negedge clk);
         mode = 1'($urandom);
         if (out_valid) break;
         chk("cmp_busy", int'(busy), 1);
         chk("cmp_in_ready", int'(in_ready), 0);
         busy_cnt += int'(busy);
         if (c == 0) begin
            chk("bf0_inr", int'(bf_inr), xr[0]);
            chk("bf0_ini", int'(bf_ini), xi[0]);
            chk("bf0_yr", int'(bf_yr), xr[4]);
            chk("bf0_yi", int'(bf_yi), xi[4]);
            chk("bf0_wr", int'(bf_wr), 255);
            chk("bf0_wi", int'(bf_wi), 0);
         end
         if (c >= 8 && c < 12) begin
            chk($sformatf("tw_s2_r[%0d]", c - 8), int'(bf_wr), twr[m][c - 8]);
            chk($sformatf("tw_s2_i[%0d]", c - 8), int'(bf_wi), twi[m][c - 8]);
         end
         c++;
      end
      chk("latency", c, 12);
   endtask

   // Entered at the negedge where the first out_valid is visible; exits just after the final accepting edge
   task automatic unload_phase(input int pol);
      int j = 0;
      int to = 0;
      if (pol == 1) out_ready = 1'b0;
      while (j < 8 && to < 100) begin
         to++;
         chk("unl_valid", int'(out_valid), 1);
         chk("unl_in_ready", int'(in_ready), 0);
         chk("unl_busy", int'(busy), 1);
         busy_cnt += int'(busy);
         chk($sformatf("out_re[%0d]", j), int'(out_re), er[j]);
         chk($sformatf("out_im[%0d]", j), int'(out_im), ei[j]);
         case (pol)
            0:       out_ready = 1'b1;
            1:       out_ready = ~out_ready;
            default: out_ready = 1'($urandom);
         endcase
         @(posedge clk);
         if (out_ready) j++;
         if (j < 8) @(negedge clk);
      end
      if (j < 8) chk("unl_timeout", j, 8);
   endtask

   task automatic run_frame(input int m, input bit gaps, input int pol);
      model(m);
      load_frame(m, gaps);
      compute_phase(m);
      unload_phase(pol);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_in_ready"}, int'(in_ready), 0);
      chk({tag, "_out_valid"}, int'(out_valid), 0);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_out_re"}, int'(out_re), 0);
      chk({tag, "_out_im"}, int'(out_im), 0);
      chk({tag, "_bf_inr"}, int'(bf_inr), 0);
      chk({tag, "_bf_yr"}, int'(bf_yr), 0);
      chk({tag, "_bf_wr"}, int'(bf_wr), 0);
      chk({tag, "_bf_wi"}, int'(bf_wi), 0);
   endtask

   initial begin
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk_all_zero("rst");
      rst_n = 1'b1;

      // Ramp x[n]=(n,0), forward: first butterfly sees mem[0]=x0, mem[1]=x4
      for (int n = 0; n < 8; n++) begin
         xr[n] = n;
         xi[n] = 0;
      end
      run_frame(0, 1'b0, 0);

      // Impulse, forward, always ready: flat spectrum and 20 busy cycles
      for (int n = 0; n < 8; n++) begin
         xr[n] = 0;
         xi[n] = 0;
      end
      xr[0] = 64;
      run_frame(0, 1'b0, 0);
      chk("impulse_busy_cycles", busy_cnt, 20);
      chk("impulse_x7_re", er[7], 64);

      // Inverse frame with input gaps and toggled out_ready
      rand_frame();
      run_frame(1, 1'b1, 1);

      // Forward frame with toggled out_ready
      rand_frame();
      run_frame(0, 1'b1, 1);

      // Reset pulse at butterfly 5 aborts the frame
      rand_frame();
      model(0);
      load_frame(0, 1'b0);
      repeat (6) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk_all_zero("midrst");
      @(negedge clk);
      chk_all_zero("midrst_hold");
      rst_n = 1'b1;
      rand_frame();
      run_frame(1, 1'b0, 0);

      // Back-to-back frames with in_valid held high, alternating direction
      for (int f = 0; f < 6; f++) begin
         rand_frame();
         run_frame(f % 2, 1'b0, 2);
      end

      @(negedge clk);
      chk("idle_in_ready", int'(in_ready), 1);
      chk("idle_out_valid", int'(out_valid), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
